// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: bus widths, opcode constants, ID/EX layout and divider states for the execute stage
package ex_stage_pkg;
  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_ID_WD  = 38;
  localparam int STALL_WD     = 6;
  localparam logic [5:0] FUNC_DIV  = 6'h1a;
  localparam logic [5:0] FUNC_DIVU = 6'h1b;
  localparam logic [5:0] FUNC_MFHI = 6'h10;
  localparam logic [5:0] FUNC_MFLO = 6'h12;
  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  src1;
    logic [3:0]  src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_ex_t;
endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: pipeline buses, stall vector and data-SRAM request seen by the execute stage
interface ex_stage_if;
  import ex_stage_pkg::*;
  logic [STALL_WD-1:0]     stall;
  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [EX_TO_ID_WD-1:0]  ex_to_id_bus;
  logic                    ex_is_load;
  logic                    stallreq_for_ex;
  logic                    data_sram_en;
  logic [3:0]              data_sram_wen;
  logic [31:0]             data_sram_addr;
  logic [31:0]             data_sram_wdata;
  modport master (
    input  stall, id_to_ex_bus,
    output ex_to_mem_bus, ex_to_id_bus, ex_is_load, stallreq_for_ex,
           data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );
  modport slave (
    output stall, id_to_ex_bus,
    input  ex_to_mem_bus, ex_to_id_bus, ex_is_load, stallreq_for_ex,
           data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/ex_stage_div_iter.sv
// div_iter: 32-step restoring divider (div/divu) with start/busy/done handshake and sign fix-up
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);
  div_state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [31:0] r_q, r_d, q_q, q_d, d_q, d_d, a_q, a_d;
  logic nq_q, nq_d, nr_q, nr_d, z_q, z_d;
  logic [32:0] sh;
  logic [33:0] diff;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    r_d = r_q;
    q_d = q_q;
    d_d = d_q;
    a_d = a_q;
    nq_d = nq_q;
    nr_d = nr_q;
    z_d = z_q;
    sh = {r_q, q_q[31]};
    diff = {1'b0, sh} - {2'b0, d_q};
    if (state_q == DIV_IDLE && start) begin
      state_d = DIV_BUSY;
      cnt_d = '0;
      r_d = '0;
      q_d = signed_op && a[31] ? -a : a;
      d_d = signed_op && b[31] ? -b : b;
      a_d = a;
      nq_d = signed_op & (a[31] ^ b[31]);
      nr_d = signed_op & a[31];
      z_d = b == 32'd0;
    end else if (state_q == DIV_BUSY) begin
      r_d = diff[33] ? sh[31:0] : diff[31:0];
      q_d = {q_q[30:0], ~diff[33]};
      cnt_d = cnt_q + 5'd1;
      state_d = cnt_q == 5'd31 ? DIV_DONE : DIV_BUSY;
    end else if (state_q == DIV_DONE) begin
      state_d = DIV_IDLE;
    end
    busy = (state_q == DIV_IDLE && start) || state_q == DIV_BUSY;
    done = state_q == DIV_DONE;
    quot = z_q ? '1 : nq_q ? -q_q : q_q;
    rem = z_q ? a_q : nr_q ? -r_q : r_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q <= '0;
      r_q <= '0;
      q_q <= '0;
      d_q <= '0;
      a_q <= '0;
      nq_q <= 1'b0;
      nr_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      r_q <= r_d;
      q_q <= q_d;
      d_q <= d_d;
      a_q <= a_d;
      nq_q <= nq_d;
      nr_q <= nr_d;
      z_q <= z_d;
    end
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage (ID/EX register, ALU, SRAM request, bypass); EX_DIV_EN adds divider and HI/LO
module ex_stage
  import ex_stage_pkg::*;
(
  input logic clk,
  input logic rst,
  ex_stage_if.master io
);
  id_ex_t ex_q, ex_d;
  logic is_r, is_mfhi, is_mflo;
  logic [5:0] func;
  logic [4:0] sh;
  logic [31:0] src1, src2, sra_res, alu_res, ex_result, hi, lo;
  logic unused_bits;
  always_comb begin
    ex_d = ~io.stall[2] ? id_ex_t'(io.id_to_ex_bus) : ~io.stall[3] ? '0 : ex_q;
  end
  always_ff @(posedge clk) begin
    ex_q <= rst ? '0 : ex_d;
  end
  always_comb begin
    func = ex_q.inst[5:0];
    is_r = ex_q.inst[31:26] == 6'd0;
    is_mfhi = is_r && func == FUNC_MFHI;
    is_mflo = is_r && func == FUNC_MFLO;
    src1 = ex_q.src1[1] ? ex_q.pc : ex_q.src1[2] ? {27'b0, ex_q.inst[10:6]} : ex_q.rdata1;
    src2 = ex_q.src2[1] ? {{16{ex_q.inst[15]}}, ex_q.inst[15:0]} : ex_q.src2[2] ? 32'd8 :
           ex_q.src2[3] ? {16'b0, ex_q.inst[15:0]} : ex_q.rdata2;
    sh = src1[4:0];
    sra_res = $unsigned($signed(src2) >>> sh);
    alu_res = ({32{ex_q.alu_op[ALU_ADD]}}  & (src1 + src2))
            | ({32{ex_q.alu_op[ALU_SUB]}}  & (src1 - src2))
            | ({32{ex_q.alu_op[ALU_SLT]}}  & {31'b0, $signed(src1) < $signed(src2)})
            | ({32{ex_q.alu_op[ALU_SLTU]}} & {31'b0, src1 < src2})
            | ({32{ex_q.alu_op[ALU_AND]}}  & (src1 & src2))
            | ({32{ex_q.alu_op[ALU_NOR]}}  & ~(src1 | src2))
            | ({32{ex_q.alu_op[ALU_OR]}}   & (src1 | src2))
            | ({32{ex_q.alu_op[ALU_XOR]}}  & (src1 ^ src2))
            | ({32{ex_q.alu_op[ALU_SLL]}}  & (src2 << sh))
            | ({32{ex_q.alu_op[ALU_SRL]}}  & (src2 >> sh))
            | ({32{ex_q.alu_op[ALU_SRA]}}  & sra_res)
            | ({32{ex_q.alu_op[ALU_LUI]}}  & {src2[15:0], 16'b0});
    ex_result = is_mfhi ? hi : is_mflo ? lo : alu_res;
  end
  assign io.ex_to_mem_bus = {ex_q.pc, ex_q.ram_en, ex_q.ram_wen, ex_q.sel_rf_res, ex_q.rf_we,
                             ex_q.rf_waddr, ex_result};
  assign io.ex_to_id_bus = {ex_q.rf_we & ~ex_q.sel_rf_res & ~rst, ex_q.rf_waddr, ex_result};
  assign io.ex_is_load = ex_q.sel_rf_res & ~rst;
  assign io.data_sram_en = ex_q.ram_en & ~rst;
  assign io.data_sram_wen = ex_q.ram_wen & {4{~rst}};
  assign io.data_sram_addr = ex_result;
  assign io.data_sram_wdata = ex_q.rdata2;
  assign unused_bits = ^{ex_q.inst[25:16], ex_q.src1[0], ex_q.src2[0]};
`ifdef EX_DIV_EN
  logic load, div_start, div_fin, div_done_q, div_done_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, quot, rem;
  // div_done keeps a div that is held in EX after completion from starting again
  always_comb begin
    load = ~io.stall[2] | ~io.stall[3];
    div_start = is_r && (func == FUNC_DIV || func == FUNC_DIVU) && !div_done_q && !rst;
    div_done_d = load ? 1'b0 : div_fin | div_done_q;
    hi_d = div_fin ? rem : hi_q;
    lo_d = div_fin ? quot : lo_q;
  end
  always_ff @(posedge clk) begin
    div_done_q <= rst ? 1'b0 : div_done_d;
    hi_q <= rst ? '0 : hi_d;
    lo_q <= rst ? '0 : lo_d;
  end
  div_iter u_div (
    .clk(clk),
    .rst(rst),
    .start(div_start),
    .signed_op(func == FUNC_DIV),
    .a(ex_q.rdata1),
    .b(ex_q.rdata2),
    .busy(io.stallreq_for_ex),
    .done(div_fin),
    .quot(quot),
    .rem(rem)
  );
  assign hi = hi_q;
  assign lo = lo_q;
`else
  assign hi = '0;
  assign lo = '0;
  assign io.stallreq_for_ex = 1'b0;
`endif
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage (ALU, stalls, SRAM, bypass, reset; divider when EX_DIV_EN)
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  ex_stage_if io();
  ex_stage dut (.clk(clk), .rst(rst), .io(io));
  localparam logic [11:0] OP_ADD = 12'h800, OP_SUB = 12'h400, OP_SLT = 12'h200, OP_SLTU = 12'h100,
                          OP_AND = 12'h080, OP_NOR = 12'h040, OP_OR = 12'h020, OP_XOR = 12'h010,
                          OP_SLL = 12'h008, OP_SRL = 12'h004, OP_SRA = 12'h002, OP_LUI = 12'h001;
  typedef struct packed {
    logic [75:0] mem;
    logic [37:0] id;
    logic [5:0]  ctl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sreq;
  } exp_t;
  exp_t sb_q[$];
  string tag_q[$];
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
      input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2, input logic ren,
      input logic [3:0] wen, input logic we, input logic [4:0] wa, input logic sel,
      input logic [31:0] r1, input logic [31:0] r2);
    return {pc, inst, op, s1, s2, ren, wen, we, wa, sel, r1, r2};
  endfunction
  function automatic logic [158:0] mf(input logic [5:0] fn);
    return mk(32'hbfc00200, {6'h00, 10'd0, 5'd8, 5'd0, fn}, 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0,
              1'b1, 5'd8, 1'b0, 32'd0, 32'd0);
  endfunction
  function automatic exp_t ex(input logic [158:0] b, input logic [31:0] res);
    exp_t e;
    e.mem = {b[158:127], b[75], b[74:71], b[64], b[70], b[69:65], res};
    e.id = {b[70] & ~b[64], b[69:65], res};
    e.ctl = {b[64], b[75], b[74:71]};
    e.addr = res;
    e.wdata = b[31:0];
    e.sreq = 1'b0;
    return e;
  endfunction
  function automatic logic [31:0] ref_alu(input int k, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] t;
    t = {{32{b[31]}}, b} >> a[4:0];
    case (k)
      0: return a + b;
      1: return a - b;
      2: return {31'b0, (a[31] != b[31]) ? a[31] : (a < b)};
      3: return {31'b0, a < b};
      4: return a & b;
      5: return ~(a | b);
      6: return a | b;
      7: return a ^ b;
      8: return b << a[4:0];
      9: return b >> a[4:0];
      10: return t[31:0];
      11: return {b[15:0], 16'h0};
      default: return 32'd0;
    endcase
  endfunction
  task automatic compare_out();
    exp_t e;
    string t;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL sb_underflow: got empty scoreboard expected an entry");
      return;
    end
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".mem"}, 128'(io.ex_to_mem_bus), 128'(e.mem));
    check({t, ".id"}, 128'(io.ex_to_id_bus), 128'(e.id));
    check({t, ".ctl"}, 128'({io.ex_is_load, io.data_sram_en, io.data_sram_wen}), 128'(e.ctl));
    check({t, ".addr"}, 128'(io.data_sram_addr), 128'(e.addr));
    check({t, ".wdata"}, 128'(io.data_sram_wdata), 128'(e.wdata));
    check({t, ".stallreq"}, 128'(io.stallreq_for_ex), 128'(e.sreq));
  endtask
  task automatic drive(input string tag, input logic [158:0] b, input logic [5:0] st,
      input logic [158:0] eb, input logic [31:0] res);
    io.id_to_ex_bus = b;
    io.stall = st;
    sb_q.push_back(ex(eb, res));
    tag_q.push_back(tag);
    step();
    compare_out();
  endtask
  task automatic issue(input string tag, input logic [158:0] b, input logic [31:0] res);
    drive(tag, b, 6'd0, b, res);
  endtask
`ifdef EX_DIV_EN
  task automatic run_div(input string tag, input logic [5:0] fn, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] lo_e, input logic [31:0] hi_e);
    int cyc;
    io.id_to_ex_bus = mk(32'hbfc00100, {6'h00, 5'd4, 5'd5, 10'd0, fn}, 12'h0, 3'b001, 4'b0001,
                         1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b);
    io.stall = 6'd0;
    step();
    cyc = 0;
    while (io.stallreq_for_ex && cyc < 40) begin
      cyc++;
      io.stall = 6'b001111;
      step();
    end
    check({tag, ".busy_cycles"}, 128'(cyc), 128'(33));
    step();
    check({tag, ".no_restart"}, 128'(io.stallreq_for_ex), 128'(0));
    issue({tag, ".mflo"}, mf(6'h12), lo_e);
    issue({tag, ".mfhi"}, mf(6'h10), hi_e);
  endtask
`endif
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    logic [158:0] ori_b, sw_b, lw_b, b;
    logic [31:0] ra, rb;
    int k;
    rst = 1'b1;
    io.stall = 6'd0;
    io.id_to_ex_bus = '0;
    step();
    step();
    check("rst.mem", 128'(io.ex_to_mem_bus), 128'(0));
    check("rst.id", 128'(io.ex_to_id_bus), 128'(0));
    check("rst.stallreq", 128'(io.stallreq_for_ex), 128'(0));
    rst = 1'b0;
    ori_b = mk(32'hbfc00000, {6'h0d, 5'd0, 5'd1, 16'h1234}, OP_OR, 3'b001, 4'b1000, 1'b0, 4'h0,
               1'b1, 5'd1, 1'b0, 32'd0, 32'd0);
    issue("ori", ori_b, 32'h1234);
    check("ori.bypass", 128'(io.ex_to_id_bus), 128'({1'b1, 5'd1, 32'h1234}));
    sw_b = mk(32'hbfc00004, {6'h2b, 5'd2, 5'd3, 16'h0008}, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'hf,
              1'b0, 5'd0, 1'b0, 32'h100, 32'hab);
    issue("sw", sw_b, 32'h108);
    check("sw.addr", 128'(io.data_sram_addr), 128'(32'h108));
    drive("hold", ori_b, 6'b001111, sw_b, 32'h108);
    drive("bubble", ori_b, 6'b000111, '0, 32'd0);
    check("bubble.rf_we", 128'(io.ex_to_id_bus[37]), 128'(0));
    check("bubble.sram_en", 128'(io.data_sram_en), 128'(0));
    lw_b = mk(32'hbfc00008, {6'h23, 5'd2, 5'd4, 16'hfffc}, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'h0,
              1'b1, 5'd4, 1'b1, 32'h200, 32'h0);
    issue("lw", lw_b, 32'h1fc);
    rst = 1'b1;
    #1;
    check("rst_gate.is_load", 128'(io.ex_is_load), 128'(0));
    check("rst_gate.sram_en", 128'(io.data_sram_en), 128'(0));
    step();
    rst = 1'b0;
    issue("add_wrap", mk(32'h0, 32'h0, OP_ADD, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0,
          32'hffffffff, 32'd2), 32'd1);
    issue("sub_wrap", mk(32'h0, 32'h0, OP_SUB, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0,
          32'd0, 32'd1), 32'hffffffff);
    issue("slt", mk(32'h0, 32'h0, OP_SLT, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0,
          32'hffffffff, 32'd1), 32'd1);
    issue("sltu", mk(32'h0, 32'h0, OP_SLTU, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0,
          32'hffffffff, 32'd1), 32'd0);
    issue("and", mk(32'h0, 32'h0, OP_AND, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0,
          32'hff00ff00, 32'h0ff00ff0), 32'h0f000f00);
    issue("nor", mk(32'h0, 32'h0, OP_NOR, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0,
          32'h0f0f0000, 32'h000000ff), 32'hf0f0ff00);
    issue("xor", mk(32'h0, 32'h0, OP_XOR, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0,
          32'hff00ff00, 32'h0ff00ff0), 32'hf0f0f0f0);
    issue("sll_sa", mk(32'h0, {6'h0, 5'd0, 5'd2, 5'd5, 5'd4, 6'h00}, OP_SLL, 3'b100, 4'b0001, 1'b0,
          4'h0, 1'b1, 5'd5, 1'b0, 32'hdeadbeef, 32'h1), 32'h10);
    issue("srl_sa", mk(32'h0, {6'h0, 5'd0, 5'd2, 5'd5, 5'd4, 6'h02}, OP_SRL, 3'b100, 4'b0001, 1'b0,
          4'h0, 1'b1, 5'd5, 1'b0, 32'h0, 32'h80000000), 32'h08000000);
    issue("sra_sa", mk(32'h0, {6'h0, 5'd0, 5'd2, 5'd5, 5'd4, 6'h03}, OP_SRA, 3'b100, 4'b0001, 1'b0,
          4'h0, 1'b1, 5'd5, 1'b0, 32'h0, 32'h80000000), 32'hf8000000);
    issue("lui", mk(32'h0, {6'h0f, 5'd0, 5'd6, 16'habcd}, OP_LUI, 3'b001, 4'b1000, 1'b0, 4'h0,
          1'b1, 5'd6, 1'b0, 32'h77, 32'h0), 32'habcd0000);
    issue("jal_link", mk(32'hbfc00010, {6'h03, 26'h10}, OP_ADD, 3'b010, 4'b0100, 1'b0, 4'h0,
          1'b1, 5'd31, 1'b0, 32'h0, 32'h0), 32'hbfc00018);
    issue("zero_op", mk(32'h0, 32'h0, 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd7, 1'b0,
          32'd5, 32'd6), 32'd0);
    for (int i = 0; i < 24; i++) begin
      k = int'($urandom_range(0, 11));
      ra = $urandom;
      rb = $urandom;
      b = mk(32'h0, 32'h0, OP_ADD >> k, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd9, 1'b0, ra, rb);
      issue($sformatf("rand%0d_op%0d", i, k), b, ref_alu(k, ra, rb));
    end
`ifdef EX_DIV_EN
    run_div("divu100_7", 6'h1b, 32'd100, 32'd7, 32'd14, 32'd2);
    run_div("div_m7_2", 6'h1a, 32'hfffffff9, 32'd2, 32'hfffffffd, 32'hffffffff);
    run_div("div5_0", 6'h1a, 32'd5, 32'd0, 32'hffffffff, 32'd5);
    io.id_to_ex_bus = mk(32'hbfc00100, {6'h00, 5'd4, 5'd5, 10'd0, 6'h1b}, 12'h0, 3'b001, 4'b0001,
                         1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd100, 32'd7);
    io.stall = 6'd0;
    step();
    for (int i = 0; i < 11; i++) begin
      io.stall = 6'b001111;
      step();
    end
    check("rst_mid.busy_before", 128'(io.stallreq_for_ex), 128'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid.stallreq_after", 128'(io.stallreq_for_ex), 128'(0));
    issue("rst_mid.mflo", mf(6'h12), 32'd0);
    issue("rst_mid.mfhi", mf(6'h10), 32'd0);
    run_div("divu1003_10", 6'h1b, 32'd1003, 32'd10, 32'd100, 32'd3);
`else
    issue("nodiv", mk(32'hbfc00100, {6'h00, 5'd4, 5'd5, 10'd0, 6'h1a}, 12'h0, 3'b001, 4'b0001,
          1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd100, 32'd7), 32'd0);
    issue("nodiv.mfhi", mk(32'h0, {6'h00, 10'd0, 5'd8, 5'd0, 6'h10}, OP_OR, 3'b001, 4'b0001, 1'b0,
          4'h0, 1'b1, 5'd8, 1'b0, 32'h55, 32'h0), 32'd0);
    issue("nodiv.mflo", mf(6'h12), 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
